hwlp_regfile_n: RTL
===================

HWLP_REGFILE_N -- requirements
Module: hwlp_regfile_n

Interface
REQ-001 SHALL provide parameter N_LOOPS, default 2: number of hardware loops, range 1..8.
REQ-002 SHALL provide parameter ADDR_W, default 32: width of the start and end address fields.
REQ-003 SHALL provide parameter CNT_W, default 32: iteration counter width.
REQ-004 Port list; one clock, reset asynchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- we_i  in  1  register write strobe.
- sel_i  in  2  write target: 00 start, 01 end, 10 count, 11 reserved.
- idx_i  in  $clog2(N_LOOPS) (min 1)  loop index for the write.
- wdata_i  in  max(ADDR_W,CNT_W)  write data, LSB-aligned.
- instr_valid_i  in  1  the ID instruction is valid.
- id_ready_i  in  1  ID stage retires the instruction this cycle.
- pc_id_i  in  ADDR_W  PC of the ID instruction.
- err_clr_i  in  1  clears the configuration error flag.
- hwlp_start_o  out  N_LOOPS x ADDR_W  start addresses.
- hwlp_end_o  out  N_LOOPS x ADDR_W  end addresses (last instruction of the loop body).
- hwlp_cnt_o  out  N_LOOPS x CNT_W  remaining iterations.
- hwlp_active_o  out  N_LOOPS  per loop: count != 0.
- hwlp_jump_o  out  1  branch back to a loop start.
- hwlp_target_o  out  ADDR_W  jump target.
- hwlp_cfg_err_o  out  1  sticky configuration error.

Function
REQ-005 On a write (we_i=1, idx_i<N_LOOPS, sel_i!=11), the field selected by sel_i of loop idx_i SHALL take the low bits of wdata_i at the next rising clk.
REQ-006 A write with idx_i>=N_LOOPS or sel_i=11 SHALL be ignored; no state changes.
REQ-007 Loop k SHALL match when instr_valid_i=1, pc_id_i==hwlp_end_o[k] and hwlp_cnt_o[k]!=0.
REQ-008 When several loops match, the lowest index SHALL win (innermost loop); only the winner is acted on.
REQ-009 hwlp_jump_o SHALL be combinational and equal 1 when the winning loop has cnt>1.
- hwlp_target_o SHALL be hwlp_start_o[winner] in that case, and 0 otherwise.
REQ-010 When the winner exists and id_ready_i=1, its count SHALL decrement by 1 at the next edge.
- cnt==1 goes to 0: no jump, the loop exits and hwlp_active_o[k] falls.
REQ-011 With id_ready_i=0 (stall), the jump output SHALL still be driven but no counter SHALL change.
REQ-012 A count never decrements below 0, so there is no wrap. An inactive loop (cnt=0) never matches.
REQ-013 A count write and a decrement of the same loop in the same cycle: the write SHALL win.
- A write to another loop's count is independent and both take effect.
REQ-014 Start and end writes SHALL NOT affect match detection until the cycle after the write.
REQ-015 Outputs hwlp_start_o, hwlp_end_o and hwlp_cnt_o SHALL be registered state; hwlp_active_o is decoded from it.

Reset
REQ-016 When rst is asserted, all start, end and count registers and hwlp_cfg_err_o SHALL clear to 0 immediately, regardless of clk.
- Consequently hwlp_active_o=0 and hwlp_jump_o=0.
REQ-017 A write or decrement coincident with reset assertion SHALL be discarded.
REQ-018 After reset deasserts, the first write SHALL take effect on the first following edge.

Configuration
REQ-019 Macro HWLP_CFG_CHECK_EN, when defined:
- at each edge, hwlp_cfg_err_o SHALL set if the next-state of any loop k has cnt!=0 and end<start;
- it stays set until err_clr_i=1;
- if set and clear conditions occur together, set SHALL win.
REQ-020 Without HWLP_CFG_CHECK_EN, hwlp_cfg_err_o SHALL be constant 0 and no comparator logic SHALL be built.

Structure
REQ-021 A shared package SHALL hold:
- the sel_i encoding enum (HWLP_SEL_START, HWLP_SEL_END, HWLP_SEL_CNT);
- the constant HWLP_MAX_LOOPS=8.
REQ-022 The lowest-index match priority encoder SHALL be a sub-module named hwlp_prio_enc, parameterised by N_LOOPS.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write loop0 start=0x100, end=0x120, cnt=3, then present pc=0x120 with id_ready=1 three times -> jump=1, target=0x100, cnt 3->2, then jump=1, cnt 2->1, then jump=0, cnt 1->0, active[0]=0.
- Nested: loop0 end=0x140, cnt=2; loop1 end=0x140, cnt=5; pc=0x140 -> loop0 wins, target=start[0], only cnt[0] decrements.
- Stall: cnt=4, pc=end, id_ready=0 for 3 cycles -> jump=1 each cycle, cnt stays 4.
- Count write to 7 in the same cycle as a decrement of that loop -> cnt=7 next cycle.
- Reset mid-loop with cnt=9 -> all outputs 0 at once, ignoring clk.
- With HWLP_CFG_CHECK_EN: start=0x200, end=0x1F0, cnt=1 -> cfg_err=1 next edge, stays until err_clr. Without the macro -> cfg_err=0.

Source files
------------

// File: rtl/hwlp_regfile_n_pkg.sv
// hwlp_regfile_n_pkg: shared write-select encoding and loop-count limit for the hardware-loop register file.
package hwlp_regfile_n_pkg;
    localparam int HWLP_MAX_LOOPS = 8;
    typedef enum logic [1:0] {
        HWLP_SEL_START = 2'b00,
        HWLP_SEL_END   = 2'b01,
        HWLP_SEL_CNT   = 2'b10
    } hwlp_sel_e;
endpackage

// File: rtl/hwlp_regfile_n_prio_enc.sv
// hwlp_prio_enc: lowest-index-wins priority encoder selecting the innermost matching loop.
module hwlp_prio_enc #(
    parameter int N_LOOPS = 2,
    localparam int IDX_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic [N_LOOPS-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        idx = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--)
            idx = req[i] ? IDX_W'(i) : idx;
    end
    assign valid = |req;
endmodule

// File: rtl/hwlp_regfile_n.sv
// hwlp_regfile_n: N hardware-loop start/end/count registers with end-of-body match and branch-back.
// Optional HWLP_CFG_CHECK_EN adds a sticky end<start configuration error flag.
module hwlp_regfile_n
    import hwlp_regfile_n_pkg::*;
#(
    parameter int N_LOOPS = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W = 32,
    localparam int IDX_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1,
    localparam int DATA_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [1:0]                sel_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      instr_valid_i,
    input  logic                      id_ready_i,
    input  logic [ADDR_W-1:0]         pc_id_i,
    input  logic                      err_clr_i,
    output logic [N_LOOPS*ADDR_W-1:0] hwlp_start_o,
    output logic [N_LOOPS*ADDR_W-1:0] hwlp_end_o,
    output logic [N_LOOPS*CNT_W-1:0]  hwlp_cnt_o,
    output logic [N_LOOPS-1:0]        hwlp_active_o,
    output logic                      hwlp_jump_o,
    output logic [ADDR_W-1:0]         hwlp_target_o,
    output logic                      hwlp_cfg_err_o
);
    if (N_LOOPS < 1 || N_LOOPS > HWLP_MAX_LOOPS) begin : g_bad_loops
        $error("hwlp_regfile_n: N_LOOPS out of range");
    end

    logic [ADDR_W-1:0] start_q [N_LOOPS];
    logic [ADDR_W-1:0] end_q   [N_LOOPS];
    logic [CNT_W-1:0]  cnt_q   [N_LOOPS];
    logic [ADDR_W-1:0] start_nx[N_LOOPS];
    logic [ADDR_W-1:0] end_nx  [N_LOOPS];
    logic [CNT_W-1:0]  cnt_nx  [N_LOOPS];
    logic [N_LOOPS-1:0] match, wr_k, dec_k, bad;
    logic [IDX_W-1:0] win;
    logic hit, wr_ok;

    assign wr_ok = we_i && (int'(idx_i) < N_LOOPS) && (sel_i != 2'b11);

    for (genvar k = 0; k < N_LOOPS; k++) begin : g_loop
        assign match[k] = instr_valid_i && (pc_id_i == end_q[k]) && (|cnt_q[k]);
        assign wr_k[k]  = wr_ok && (idx_i == IDX_W'(k));
        assign dec_k[k] = hit && id_ready_i && (win == IDX_W'(k));
        assign start_nx[k] = (wr_k[k] && sel_i == HWLP_SEL_START) ? wdata_i[ADDR_W-1:0] : start_q[k];
        assign end_nx[k]   = (wr_k[k] && sel_i == HWLP_SEL_END) ? wdata_i[ADDR_W-1:0] : end_q[k];
        // a count write overrides a same-cycle decrement of that loop
        assign cnt_nx[k]   = (wr_k[k] && sel_i == HWLP_SEL_CNT) ? wdata_i[CNT_W-1:0] :
                             dec_k[k] ? cnt_q[k] - CNT_W'(1) : cnt_q[k];
        assign bad[k] = (|cnt_nx[k]) && (end_nx[k] < start_nx[k]);
        assign hwlp_start_o[k*ADDR_W +: ADDR_W] = start_q[k];
        assign hwlp_end_o[k*ADDR_W +: ADDR_W]   = end_q[k];
        assign hwlp_cnt_o[k*CNT_W +: CNT_W]     = cnt_q[k];
        assign hwlp_active_o[k] = |cnt_q[k];
    end

    hwlp_prio_enc #(.N_LOOPS(N_LOOPS)) u_prio (
        .req  (match),
        .valid(hit),
        .idx  (win)
    );

    assign hwlp_jump_o   = hit && (cnt_q[win] > CNT_W'(1));
    assign hwlp_target_o = hwlp_jump_o ? start_q[win] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '{default: '0};
            end_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            start_q <= start_nx;
            end_q   <= end_nx;
            cnt_q   <= cnt_nx;
        end
    end

`ifdef HWLP_CFG_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= (|bad) || (err_q && !err_clr_i);
    end
    assign hwlp_cfg_err_o = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = err_clr_i ^ (|bad);
    assign hwlp_cfg_err_o = 1'b0;
`endif
endmodule
